// File: rtl/frog_game_ctrl_if.sv
// Button pulses in, board state out: the link between the frog game sequencer
// and its input/renderer side.
interface frog_game_ctrl_if;
  logic        up;
  logic        left;
  logic        right;
  logic [15:0] car1;
  logic [15:0] car3;
  logic [15:0] car5;
  logic [15:0] car6;
  logic [15:0] displayPattern;
  logic [3:0]  displayRow;
  logic        win;
  logic        lose;
  logic [3:0]  score;

  modport master (
    output up, left, right,
    input  car1, car3, car5, car6, displayPattern, displayRow, win, lose, score
  );

  modport slave (
    input  up, left, right,
    output car1, car3, car5, car6, displayPattern, displayRow, win, lose, score
  );
endinterface

// File: rtl/frog_game_ctrl.sv
// Frog crossing game sequencer: frog position, scrolling car lanes, collision
// detection and the PLAY/HIT/WIN state machine with a saturating score.
module frog_game_ctrl #(
  parameter int unsigned TICK_DIV  = 8,
  parameter logic [15:0] CAR1_INIT = 16'b1000100000001000,
  parameter logic [15:0] CAR3_INIT = 16'b0001000001000001,
  parameter logic [15:0] CAR5_INIT = 16'b0100000100000100,
  parameter logic [15:0] CAR6_INIT = 16'b0000011000000110
) (
  input logic              clk,
  input logic              reset,
  frog_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {PLAY, HIT, WIN} state_t;

  localparam logic [15:0] FROG_HOME = 16'b0000000100000000;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_t      state, state_nx;
  logic [3:0]  row, row_nx;
  logic [15:0] pat, pat_nx;
  logic [15:0] c1, c1_nx, c3, c3_nx, c5, c5_nx, c6, c6_nx;
  logic [15:0] cnt;
  logic [3:0]  score, score_nx;
  logic        tick;
  logic        hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PLAY;
      row   <= '0;
      pat   <= FROG_HOME;
      c1    <= CAR1_INIT;
      c3    <= CAR3_INIT;
      c5    <= CAR5_INIT;
      c6    <= CAR6_INIT;
      cnt   <= '0;
      score <= '0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      pat   <= pat_nx;
      c1    <= c1_nx;
      c3    <= c3_nx;
      c5    <= c5_nx;
      c6    <= c6_nx;
      cnt   <= tick ? '0 : cnt + 16'd1;
      score <= score_nx;
    end
  end

  always_comb begin
    tick = (cnt == TICK_LAST);
    hit  = ((row == 4'd1) && ((c1 & pat) != '0)) ||
           ((row == 4'd3) && ((c3 & pat) != '0)) ||
           ((row == 4'd5) && ((c5 & pat) != '0)) ||
           ((row == 4'd6) && ((c6 & pat) != '0));
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    pat_nx   = pat;
    c1_nx    = c1;
    c3_nx    = c3;
    c5_nx    = c5;
    c6_nx    = c6;
    score_nx = score;
    case (state)
      PLAY: begin
        // A collision freezes everything for this edge, including the lanes.
        if (hit) begin
          state_nx = HIT;
        end else begin
          if (tick) begin
            c1_nx = {c1[14:0], c1[15]};
            c5_nx = {c5[14:0], c5[15]};
            c3_nx = {c3[0], c3[15:1]};
            c6_nx = {c6[0], c6[15:1]};
          end
          if (bus.up) begin
            if (row == 4'd7) begin
              state_nx = WIN;
              if (score != 4'd15) score_nx = score + 4'd1;
            end else begin
              row_nx = row + 4'd1;
            end
          end else if (bus.left && !bus.right) begin
            if (!pat[15]) pat_nx = pat << 1;
          end else if (bus.right && !bus.left) begin
            if (!pat[0]) pat_nx = pat >> 1;
          end
        end
      end
      HIT, WIN: begin
        if (bus.up) begin
          state_nx = PLAY;
          row_nx   = '0;
          pat_nx   = FROG_HOME;
        end
      end
      default: state_nx = PLAY;
    endcase
  end

  assign bus.car1           = c1;
  assign bus.car3           = c3;
  assign bus.car5           = c5;
  assign bus.car6           = c6;
  assign bus.displayPattern = pat;
  assign bus.displayRow     = row;
  assign bus.win            = (state == WIN);
  assign bus.lose           = (state == HIT);
  assign bus.score          = score;

endmodule
